// File: rtl/pulse_interval_meter.sv
// pulse_interval_meter
//
// Measures the number of clock cycles between consecutive single-cycle pulses
// from the upstream edge detector. Each interval is queued in a small
// first-word-fall-through FIFO that a consumer drains over valid/ready.
// A measurement that runs to TIMEOUT-1 cycles without a pulse is aborted with
// a one-cycle strobe. A record arriving at a full FIFO with no pop in the same
// cycle is dropped and sets the sticky overflow flag.
//
// Optional build macro: PULSE_INTERVAL_MINMAX_EN
//   When defined, min_o/max_o track the smallest/largest accepted interval.
//   When undefined, min_o is tied to all-ones and max_o to zero.
//
// Ports:
//   clk           clock
//   rst_n         asynchronous active-low reset
//   pulse_in      single-cycle event pulse
//   clr           synchronous clear of FSM, FIFO, flags and min/max
//   m_valid       FIFO head holds a valid interval (decoded from FIFO state)
//   m_ready       consumer accepts the head this cycle
//   m_data        interval at the FIFO head, 0 when empty
//   fifo_level    current FIFO occupancy
//   timeout_pulse one-cycle strobe when a measurement times out
//   overflow      sticky flag, set when a record is dropped
//   min_o/max_o   smallest/largest accepted interval

module pulse_interval_meter #(
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned TIMEOUT    = 50000
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          pulse_in,
  input  logic                          clr,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic [CNT_W-1:0]              m_data,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          timeout_pulse,
  output logic                          overflow,
  output logic [CNT_W-1:0]              min_o,
  output logic [CNT_W-1:0]              max_o
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;

  localparam logic [CNT_W-1:0] CntLast = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CntOne  = CNT_W'(1);
  localparam logic [LVL_W-1:0] LvlFull = LVL_W'(FIFO_DEPTH);

  typedef enum logic [0:0] {StIdle, StMeas} state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              timeout_q, timeout_d;
  logic              overflow_q, overflow_d;

  logic [CNT_W-1:0]  mem_q [FIFO_DEPTH];
  logic [CNT_W-1:0]  mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]  level_q, level_d;

  logic not_empty;
  logic full;
  logic pop;
  logic push_req;
  logic push;
  logic drop;

  // Handshake and push decode. clr suppresses both sides so that it wins over
  // every other event in the same cycle.
  always_comb begin
    not_empty = (level_q != '0);
    full      = (level_q == LvlFull);
    pop       = not_empty && m_ready && !clr;
    push_req  = (state_q == StMeas) && pulse_in && !clr;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    push      = push_req && (!full || pop);
    drop      = push_req && full && !pop;
  end

  // Measurement FSM and flags.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    timeout_d  = 1'b0;
    overflow_d = overflow_q | drop;

    if (clr) begin
      state_d    = StIdle;
      cnt_d      = '0;
      overflow_d = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (pulse_in) begin
            state_d = StMeas;
            cnt_d   = CntOne;
          end
        end
        StMeas: begin
          // A pulse on the last allowed cycle wins over the timeout.
          if (pulse_in) begin
            cnt_d = CntOne;
          end else if (cnt_q == CntLast) begin
            state_d   = StIdle;
            cnt_d     = '0;
            timeout_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CntOne;
          end
        end
        default: begin
          state_d = StIdle;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      timeout_q  <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      timeout_q  <= timeout_d;
      overflow_q <= overflow_d;
    end
  end

  // FIFO next state. Pointers wrap naturally because FIFO_DEPTH is a power of 2.
  always_comb begin
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      mem_d[i] = mem_q[i];
    end
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;

    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = cnt_q;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      level_d = level_q + LVL_W'(push) - LVL_W'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Head is presented straight from FIFO state; zero while empty.
  always_comb begin
    m_valid = not_empty;
    m_data  = not_empty ? mem_q[rd_ptr_q] : '0;
  end

  assign fifo_level    = level_q;
  assign timeout_pulse = timeout_q;
  assign overflow      = overflow_q;

`ifdef PULSE_INTERVAL_MINMAX_EN
  logic [CNT_W-1:0] min_q, min_d;
  logic [CNT_W-1:0] max_q, max_d;

  // Only records that actually enter the FIFO update the statistics.
  always_comb begin
    min_d = min_q;
    max_d = max_q;
    if (clr) begin
      min_d = '1;
      max_d = '0;
    end else if (push) begin
      if (cnt_q < min_q) begin
        min_d = cnt_q;
      end
      if (cnt_q > max_q) begin
        max_d = cnt_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      min_q <= '1;
      max_q <= '0;
    end else begin
      min_q <= min_d;
      max_q <= max_d;
    end
  end

  assign min_o = min_q;
  assign max_o = max_q;
`else
  assign min_o = '1;
  assign max_o = '0;
`endif

endmodule

// File: tb/tb_pulse_interval_meter.sv
module tb_pulse_interval_meter;

  localparam int unsigned CNT_W      = 16;
  localparam int unsigned FIFO_DEPTH = 4;
  localparam int unsigned TIMEOUT    = 20;
  localparam int unsigned LVL_W      = $clog2(FIFO_DEPTH) + 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             pulse_in = 1'b0;
  logic             clr = 1'b0;
  logic             m_ready = 1'b0;
  logic             m_valid;
  logic [CNT_W-1:0] m_data;
  logic [LVL_W-1:0] fifo_level;
  logic             timeout_pulse;
  logic             overflow;
  logic [CNT_W-1:0] min_o;
  logic [CNT_W-1:0] max_o;

  always #5 clk = ~clk;

  pulse_interval_meter #(
    .CNT_W      (CNT_W),
    .FIFO_DEPTH (FIFO_DEPTH),
    .TIMEOUT    (TIMEOUT)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .pulse_in      (pulse_in),
    .clr           (clr),
    .m_valid       (m_valid),
    .m_ready       (m_ready),
    .m_data        (m_data),
    .fifo_level    (fifo_level),
    .timeout_pulse (timeout_pulse),
    .overflow      (overflow),
    .min_o         (min_o),
    .max_o         (max_o)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int to_seen  = 0;

  // Scoreboard of intervals expected to leave the FIFO, in order.
  logic [CNT_W-1:0] sb_q[$];

  // Bench-side interval model.
  bit               armed    = 1'b0;
  int               last_cyc = 0;
  logic [CNT_W-1:0] exp_min  = '1;
  logic [CNT_W-1:0] exp_max  = '0;

  typedef struct {
    int unsigned      gap;
    bit               rec;
    logic [CNT_W-1:0] val;
    bit               to;
  } vec_t;

  vec_t vecs[8];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: count timeout strobes, compare every completed handshake.
  always @(negedge clk) begin
    if (timeout_pulse === 1'b1) to_seen++;
    if (rst_n && m_valid && m_ready && !clr) begin
      if (sb_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_pop: got %0d expected no record", m_data);
      end else begin
        check("pop_data", m_data, sb_q.pop_front());
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic flush_model();
    sb_q.delete();
    armed   = 1'b0;
    exp_min = '1;
    exp_max = '0;
  endtask

  // Drive one pulse; accept says whether the bench expects the FIFO to take it.
  task automatic fire(input bit accept);
    int iv;
    iv = cyc - last_cyc;
    if (armed && iv <= int'(TIMEOUT) - 1 && accept) begin
      sb_q.push_back(CNT_W'(iv));
`ifdef PULSE_INTERVAL_MINMAX_EN
      if (CNT_W'(iv) < exp_min) exp_min = CNT_W'(iv);
      if (CNT_W'(iv) > exp_max) exp_max = CNT_W'(iv);
`endif
    end
    armed    = 1'b1;
    last_cyc = cyc;
    pulse_in = 1'b1;
    step();
    pulse_in = 1'b0;
  endtask

  task automatic do_clear();
    clr = 1'b1;
    step();
    clr = 1'b0;
    flush_model();
  endtask

  initial begin
    int t0;

    vecs[0] = '{gap: 5,  rec: 1'b1, val: 16'd5,  to: 1'b0};
    vecs[1] = '{gap: 1,  rec: 1'b1, val: 16'd1,  to: 1'b0};
    vecs[2] = '{gap: 3,  rec: 1'b1, val: 16'd3,  to: 1'b0};
    vecs[3] = '{gap: 19, rec: 1'b1, val: 16'd19, to: 1'b0};
    vecs[4] = '{gap: 20, rec: 1'b0, val: 16'd0,  to: 1'b1};
    vecs[5] = '{gap: 7,  rec: 1'b1, val: 16'd7,  to: 1'b0};
    vecs[6] = '{gap: 25, rec: 1'b0, val: 16'd0,  to: 1'b1};
    vecs[7] = '{gap: 2,  rec: 1'b1, val: 16'd2,  to: 1'b0};

    // Reset state
    idle(3);
    rst_n = 1'b1;
    step();
    check("rst_m_valid", m_valid, 0);
    check("rst_m_data", m_data, 0);
    check("rst_level", fifo_level, 0);
    check("rst_timeout", timeout_pulse, 0);
    check("rst_overflow", overflow, 0);
    check("rst_min", min_o, 16'hFFFF);
    check("rst_max", max_o, 0);

    // Table: gaps, pulse-wins-at-limit, timeouts and re-arm
    m_ready = 1'b1;
    idle(6);
    fire(1'b1);
    for (int i = 0; i < 8; i++) begin
      t0 = to_seen;
      idle(int'(vecs[i].gap) - 1);
      fire(1'b1);
      check($sformatf("vec%0d_valid", i), m_valid, vecs[i].rec);
      if (vecs[i].rec) check($sformatf("vec%0d_data", i), m_data, vecs[i].val);
      check($sformatf("vec%0d_timeouts", i), to_seen - t0, vecs[i].to);
    end
    step();
    check("tbl_level_end", fifo_level, 0);
    check("tbl_sb_drained", sb_q.size(), 0);

    // Overflow: six pulses with the consumer stalled
    do_clear();
    m_ready = 1'b0;
    fire(1'b1);
    for (int i = 0; i < 4; i++) begin
      idle(2);
      fire(1'b1);
    end
    idle(2);
    fire(1'b0);
    check("ovf_level", fifo_level, 4);
    check("ovf_flag", overflow, 1);
    check("ovf_head", m_data, 3);
    m_ready = 1'b1;
    idle(4);
    m_ready = 1'b0;
    check("ovf_drain_level", fifo_level, 0);
    check("ovf_sb_drained", sb_q.size(), 0);
    check("ovf_sticky", overflow, 1);

    // Full FIFO with simultaneous push and pop
    do_clear();
    check("clr_overflow", overflow, 0);
    fire(1'b1);
    for (int i = 0; i < 4; i++) begin
      idle(2);
      fire(1'b1);
    end
    idle(5);
    m_ready = 1'b1;
    fire(1'b1);
    m_ready = 1'b0;
    check("pp_level", fifo_level, 4);
    check("pp_overflow", overflow, 0);
    check("pp_head", m_data, 3);
    m_ready = 1'b1;
    idle(4);
    m_ready = 1'b0;
    check("pp_drain_level", fifo_level, 0);
    check("pp_sb_drained", sb_q.size(), 0);

    // clr together with a pulse while two entries are queued
    do_clear();
    fire(1'b1);
    idle(3);
    fire(1'b1);
    idle(3);
    fire(1'b1);
    check("clr_pre_level", fifo_level, 2);
    idle(3);
    clr      = 1'b1;
    pulse_in = 1'b1;
    step();
    clr      = 1'b0;
    pulse_in = 1'b0;
    flush_model();
    check("clr_level", fifo_level, 0);
    check("clr_m_valid", m_valid, 0);
    check("clr_m_data", m_data, 0);
    check("clr_ovf", overflow, 0);
    m_ready = 1'b1;
    idle(2);
    fire(1'b1);
    check("clr_pulse_ignored", m_valid, 0);
    idle(2);
    fire(1'b1);
    check("clr_rearm_valid", m_valid, 1);
    check("clr_rearm_data", m_data, 3);
    step();
    check("clr_sb_drained", sb_q.size(), 0);

    // Min/max statistics
    do_clear();
    fire(1'b1);
    idle(6);
    fire(1'b1);
    idle(2);
    fire(1'b1);
    idle(11);
    fire(1'b1);
    step();
    check("mm_min", min_o, exp_min);
    check("mm_max", max_o, exp_max);
    check("mm_sb_drained", sb_q.size(), 0);
    do_clear();
    check("mm_clr_min", min_o, exp_min);
    check("mm_clr_max", max_o, exp_max);

    // Reset in the middle of a measurement
    fire(1'b1);
    idle(3);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    flush_model();
    check("mid_rst_level", fifo_level, 0);
    idle(2);
    fire(1'b1);
    check("mid_rst_arm_only", m_valid, 0);
    idle(1);
    fire(1'b1);
    check("mid_rst_valid", m_valid, 1);
    check("mid_rst_data", m_data, 2);
    step();
    check("mid_rst_sb_drained", sb_q.size(), 0);
    m_ready = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
